// File: rtl/mux_4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4-input multiplexer.
// One requester is granted at a time; MAX_HOLD bounds ownership while others wait.
module mux_4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_GRANT = 1'b1;
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic       state_r;
    logic [1:0] last_r;
    logic [7:0] hold_cnt_r;
    logic [3:0] grant_r;
    logic [1:0] sel_r;
    logic       busy_r;

    logic       state_s;
    logic [1:0] last_s;
    logic [7:0] hold_cnt_s;
    logic [3:0] others_s;
    logic [1:0] win_all_s;
    logic [1:0] win_oth_s;

    // First requester found searching upward from start, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Winner candidates: any requester, or anyone except the current owner.
    always_comb begin
        others_s  = req & ~one_hot(last_r);
        win_all_s = rr_pick(req, last_r + 2'd1);
        win_oth_s = rr_pick(others_s, last_r + 2'd1);
    end

    // Next-state decision for ownership and hold counting.
    always_comb begin
        state_s    = state_r;
        last_s     = last_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_s    = ST_GRANT;
                    last_s     = win_all_s;
                    hold_cnt_s = 8'd1;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (req[last_r] && (hold_cnt_r < HOLD_MAX)) begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end else if (others_s != 4'b0000) begin
                    // Forced rotation or early release: hand over without an idle bubble.
                    last_s     = win_oth_s;
                    hold_cnt_s = 8'd1;
                end else if (req[last_r]) begin
                    hold_cnt_s = HOLD_MAX;
                end else begin
                    state_s    = ST_IDLE;
                    hold_cnt_s = 8'd0;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = 8'd0;
            end
        endcase
    end

    // State and registered outputs; sel keeps its value while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            last_r     <= 2'b11;
            hold_cnt_r <= 8'd0;
            grant_r    <= 4'b0000;
            sel_r      <= 2'b00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            last_r     <= last_s;
            hold_cnt_r <= hold_cnt_s;
            if (state_s == ST_GRANT) begin
                grant_r <= one_hot(last_s);
                sel_r   <= last_s;
                busy_r  <= 1'b1;
            end else begin
                grant_r <= 4'b0000;
                sel_r   <= sel_r;
                busy_r  <= 1'b0;
            end
        end
    end

    assign grant = grant_r;
    assign sel   = sel_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// Directed bench for mux_4_rr_arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=1,
// sharing clock, reset and request inputs. Outputs are compared as {grant, sel, busy}.
module tb_mux_4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant8, grant1;
    logic [1:0] sel8, sel1;
    logic       busy8, busy1;

    int n_checks;
    int n_fail;

    mux_4_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk(clk), .reset(reset), .req(req), .grant(grant8), .sel(sel8), .busy(busy8)
    );

    mux_4_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .grant(grant1), .sel(sel1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got grant/sel/busy=%b required %b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] owned(input logic [1:0] idx);
        logic [3:0] g;
        g = 4'b0001 << idx;
        return {g, idx, 1'b1};
    endfunction

    function automatic logic [6:0] idle(input logic [1:0] s);
        return {4'b0000, s, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with all requests held.
        reset = 1'b1;
        req   = 4'b1111;
        step();
        step();
        check("reset8", {grant8, sel8, busy8}, idle(2'b00));
        check("reset1", {grant1, sel1, busy1}, idle(2'b00));

        // Full load: MAX_HOLD=8 rotates every 8 cycles, MAX_HOLD=1 every cycle.
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            check($sformatf("rot8_%0d", k), {grant8, sel8, busy8}, owned(2'((k / 8) % 4)));
            check($sformatf("rot1_%0d", k), {grant1, sel1, busy1}, owned(2'(k % 4)));
        end

        // Single requester 2 keeps the mux with no gaps.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("solo8_%0d", k), {grant8, sel8, busy8}, owned(2'd2));
            check($sformatf("solo1_%0d", k), {grant1, sel1, busy1}, owned(2'd2));
        end

        // Early release hands over directly.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0001;
        step();
        check("own0", {grant8, sel8, busy8}, owned(2'd0));
        req = 4'b1010;
        step();
        check("early8_a", {grant8, sel8, busy8}, owned(2'd1));
        check("early1_a", {grant1, sel1, busy1}, owned(2'd1));
        req = 4'b1000;
        step();
        check("early8_b", {grant8, sel8, busy8}, owned(2'd3));
        check("early1_b", {grant1, sel1, busy1}, owned(2'd3));

        // All requests drop: idle, sel holds 3.
        req = 4'b0000;
        step();
        check("idle8", {grant8, sel8, busy8}, idle(2'b11));
        step();
        check("idle8_hold", {grant8, sel8, busy8}, idle(2'b11));
        req = 4'b0001;
        step();
        check("wake8", {grant8, sel8, busy8}, owned(2'd0));
        check("wake1", {grant1, sel1, busy1}, owned(2'd0));

        // Reset mid-grant, then requester 0 wins first.
        req = 4'b0100;
        step();
        check("pre_rst8", {grant8, sel8, busy8}, owned(2'd2));
        req   = 4'b1111;
        reset = 1'b1;
        step();
        check("midrst8", {grant8, sel8, busy8}, idle(2'b00));
        check("midrst1", {grant1, sel1, busy1}, idle(2'b00));
        reset = 1'b0;
        step();
        check("post_rst8", {grant8, sel8, busy8}, owned(2'd0));
        check("post_rst1", {grant1, sel1, busy1}, owned(2'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
